// File: rtl/memory_access_pkg.sv
// Shared encodings, FSM state type and byte-lane helpers for the
// memory-access stage.
package memory_access_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;
  localparam logic [1:0] SIZE_RSVD = 2'd3;

  localparam int DEFAULT_TIMEOUT_CYCLES = 255;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REQUEST  = 2'd1,
    COMPLETE = 2'd2
  } state_t;

  // Reserved size behaves as a word everywhere.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] offset);
    case (size)
      SIZE_BYTE: is_misaligned = 1'b0;
      SIZE_HALF: is_misaligned = offset[0];
      default:   is_misaligned = |offset;
    endcase
  endfunction

  function automatic logic [3:0] lane_enable(input logic [1:0] size, input logic [1:0] offset);
    case (size)
      SIZE_BYTE: lane_enable = 4'b0001 << offset;
      SIZE_HALF: lane_enable = offset[1] ? 4'b1100 : 4'b0011;
      default:   lane_enable = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] replicate_store(input logic [1:0] size, input logic [31:0] data);
    case (size)
      SIZE_BYTE: replicate_store = {4{data[7:0]}};
      SIZE_HALF: replicate_store = {2{data[15:0]}};
      default:   replicate_store = data;
    endcase
  endfunction

endpackage

// File: rtl/memory_access_if.sv
// Data-bus bundle between the memory-access stage (master) and memory (slave).
interface memory_access_if;
  logic        memReq;
  logic        memWe;
  logic [31:0] memAddr;
  logic [3:0]  memByteEnable;
  logic [31:0] memWdata;
  logic        memAck;
  logic [31:0] memRdata;

  modport master (
    output memReq, memWe, memAddr, memByteEnable, memWdata,
    input  memAck, memRdata
  );

  modport slave (
    input  memReq, memWe, memAddr, memByteEnable, memWdata,
    output memAck, memRdata
  );
endinterface

// File: rtl/memory_access_load_aligner.sv
// Picks the addressed byte/half/word out of a little-endian read word and
// sign- or zero-extends it to 32 bits.
module load_aligner
  import memory_access_pkg::*;
(
  input  logic [31:0] memRdata,
  input  logic [1:0]  offset,
  input  logic [1:0]  memSize,
  input  logic        signExtend,
  output logic [31:0] value
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = memRdata[{offset, 3'b000} +: 8];
    w_half = offset[1] ? memRdata[31:16] : memRdata[15:0];
    case (memSize)
      SIZE_BYTE: value = {{24{signExtend & w_byte[7]}}, w_byte};
      SIZE_HALF: value = {{16{signExtend & w_half[15]}}, w_half};
      default:   value = memRdata;
    endcase
  end

endmodule

// File: rtl/memory_access.sv
// Memory-access pipeline stage: pass-through, aligned loads/stores over a
// req/ack data bus with alignment checking and a bus timeout.
module memory_access
  import memory_access_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               memRead,
  input  logic               memWrite,
  input  logic [1:0]         memSize,
  input  logic               signExtend,
  input  logic [31:0]        address,
  input  logic [31:0]        storeData,
  memory_access_if.master    bus,
  output logic               stall,
  output logic               done,
  output logic [31:0]        resultOutput,
  output logic               addressError,
  output logic               busError
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  state_t             r_state, w_next;
  logic [CNT_W-1:0]   r_count;
  logic [31:0]        r_addr;
  logic [1:0]         r_size;
  logic               r_sext;
  logic               r_store;
  logic               r_we;
  logic [31:0]        r_mem_addr;
  logic [3:0]         r_be;
  logic [31:0]        r_wdata;
  logic [31:0]        r_result;
  logic               r_addr_err;
  logic               r_bus_err;

  logic               w_pass;
  logic               w_misal;
  logic               w_launch;
  logic               w_ack_fire;
  logic               w_timeout;
  logic [31:0]        w_load;

  load_aligner u_load_aligner (
    .memRdata   (bus.memRdata),
    .offset     (r_addr[1:0]),
    .memSize    (r_size),
    .signExtend (r_sext),
    .value      (w_load)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next     = r_state;
    w_pass     = 1'b0;
    w_misal    = 1'b0;
    w_launch   = 1'b0;
    w_ack_fire = 1'b0;
    w_timeout  = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          if (!memRead && !memWrite) begin
            w_pass = 1'b1;
            w_next = COMPLETE;
          end else if (is_misaligned(memSize, address[1:0])) begin
            w_misal = 1'b1;
            w_next  = COMPLETE;
          end else begin
            w_launch = 1'b1;
            w_next   = REQUEST;
          end
        end
      end
      REQUEST: begin
        // An ack arriving on the timeout cycle still completes normally.
        if (bus.memAck) begin
          w_ack_fire = 1'b1;
          w_next     = COMPLETE;
        end else if (r_count == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          w_timeout = 1'b1;
          w_next    = COMPLETE;
        end
      end
      COMPLETE: w_next = IDLE;
      default:  w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count    <= '0;
      r_addr     <= '0;
      r_size     <= '0;
      r_sext     <= 1'b0;
      r_store    <= 1'b0;
      r_we       <= 1'b0;
      r_mem_addr <= '0;
      r_be       <= '0;
      r_wdata    <= '0;
      r_result   <= '0;
      r_addr_err <= 1'b0;
      r_bus_err  <= 1'b0;
    end else begin
      if (w_launch) begin
        r_count    <= '0;
        r_addr     <= address;
        r_size     <= memSize;
        r_sext     <= signExtend;
        r_store    <= memWrite;
        r_we       <= memWrite;
        r_mem_addr <= {address[31:2], 2'b00};
        r_be       <= lane_enable(memSize, address[1:0]);
        r_wdata    <= replicate_store(memSize, storeData);
        r_addr_err <= 1'b0;
        r_bus_err  <= 1'b0;
      end
      if (w_pass) begin
        r_result   <= address;
        r_addr_err <= 1'b0;
        r_bus_err  <= 1'b0;
      end
      if (w_misal) begin
        r_result   <= '0;
        r_addr_err <= 1'b1;
        r_bus_err  <= 1'b0;
      end
      if (r_state == REQUEST && !bus.memAck) r_count <= r_count + CNT_W'(1);
      if (w_ack_fire) r_result <= r_store ? r_addr : w_load;
      if (w_timeout) begin
        r_result  <= '0;
        r_bus_err <= 1'b1;
      end
    end
  end

  assign bus.memReq        = (r_state == REQUEST);
  assign bus.memWe         = r_we;
  assign bus.memAddr       = r_mem_addr;
  assign bus.memByteEnable = r_be;
  assign bus.memWdata      = r_wdata;

  assign stall        = (r_state != IDLE);
  assign done         = (r_state == COMPLETE);
  assign resultOutput = r_result;
  assign addressError = r_addr_err;
  assign busError     = r_bus_err;

endmodule

// File: doc/memory_access.md
MEMORY_ACCESS -- requirements
Module: memory_access

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255, meaning the maximum cycles memReq is held without memAck before a bus error.
REQ-002 SHALL have port clk, input, 1, meaning the single clock; all state updates on rising edge.
REQ-003 SHALL have port reset, input, 1, meaning asynchronous active-low reset.
REQ-004 SHALL have port start, input, 1, meaning a one-cycle pulse that the executing-stage result and controls are valid.
REQ-005 SHALL have ports memRead and memWrite, input, 1 each, meaning the load or store request; both low means pass-through.
REQ-006 SHALL have port memSize, input, 2, meaning access size: 0 byte, 1 half, 2 word, 3 reserved (treated as word).
REQ-007 SHALL have port signExtend, input, 1, meaning sign-extend byte/half loads when high, zero-extend when low.
REQ-008 SHALL have port address, input, 32, meaning the executing-stage resultOutput used as byte address or pass-through value.
REQ-009 SHALL have port storeData, input, 32, meaning the store operand in the low bits.
REQ-010 SHALL have data-bus ports memReq out 1, memWe out 1, memAddr out 32 (bits 1:0 zero), memByteEnable out 4, memWdata out 32, memAck in 1, memRdata in 32.
REQ-011 SHALL have outputs stall 1, done 1, resultOutput 32, addressError 1, busError 1.

Function
REQ-012 SHALL implement FSM states IDLE, REQUEST, COMPLETE.
REQ-013 In IDLE, start with neither memRead nor memWrite SHALL go to COMPLETE; resultOutput = address.
REQ-014 In IDLE, start with a misaligned access (half with address[0]=1; word with address[1:0]!=0) SHALL go to COMPLETE with addressError=1, no bus request, resultOutput=0.
REQ-015 In IDLE, a valid aligned start SHALL latch all inputs and go to REQUEST; memRead and memWrite both high SHALL be treated as a store.
REQ-016 In REQUEST, memReq SHALL be high with memAddr, memWe, memByteEnable, memWdata stable until the cycle memAck is sampled high.
REQ-017 Byte lanes little-endian: byte enable = 1<<address[1:0], storeData[7:0] replicated on all lanes; half enable 4'b0011 (address[1]=0) or 4'b1100, storeData[15:0] replicated on both halves; word 4'b1111.
REQ-018 On memAck, a load SHALL extract the addressed lane(s) from memRdata, extend per signExtend to 32 bits, register into resultOutput; a store SHALL set resultOutput = address; next state COMPLETE.
REQ-019 A cycle counter SHALL clear on REQUEST entry and increment each REQUEST cycle without memAck; on reaching TIMEOUT_CYCLES the FSM SHALL drop memReq and go to COMPLETE with busError=1, resultOutput=0.
REQ-020 memAck in the same cycle as timeout SHALL win (normal completion).
REQ-021 COMPLETE SHALL assert done for exactly one cycle, then return to IDLE; resultOutput and error flags SHALL hold until the next start is accepted.
REQ-022 stall SHALL equal (state != IDLE); start while stall is high SHALL be ignored.
REQ-023 Latency: pass-through/misaligned done in cycle start+1; bus access with memAck in cycle k gives done in cycle k+1; minimum 2 cycles.
REQ-024 memAck outside REQUEST SHALL be ignored.

Reset
REQ-025 Asserting reset SHALL immediately force IDLE, counter 0, memReq 0, memWe 0, memByteEnable 0, memAddr 0, memWdata 0, done 0, stall 0, resultOutput 0, addressError 0, busError 0, including mid-REQUEST (request abandoned, no done).

Structure
REQ-026 Shared package memory_access_pkg SHALL hold the memSize encoding constants, FSM state typedef and default TIMEOUT_CYCLES.
REQ-027 Load lane extraction/extension SHALL be a combinational sub-module load_aligner (inputs memRdata, offset, memSize, signExtend; output 32-bit value).

Verification
REQ-028 Pass-through: start, no read/write, address=0x0000_1234 -> done at start+1, resultOutput=0x0000_1234, memReq never high.
REQ-029 Signed byte load: address=0x103, memRdata=0x80FF_1234, ack after 3 cycles -> memByteEnable=4'b1000, memAddr=0x100, resultOutput=0xFFFF_FF80.
REQ-030 Half store: address=0x202, storeData=0x0000_ABCD -> memByteEnable=4'b1100, memWdata=0xABCD_ABCD, memWe=1, done one cycle after ack.
REQ-031 Misaligned word load address=0x301 -> addressError=1, done at start+1, no memReq.
REQ-032 No ack with TIMEOUT_CYCLES=4 -> memReq high 4 cycles, busError=1, done pulse; second start during stall ignored.
REQ-033 reset low mid-REQUEST -> all outputs 0 asynchronously; after release, new word load completes normally.
